// File: rtl/i2c_cond_pkg.sv
// Shared types and default timing constants for the I2C line conditioner.
package i2c_cond_pkg;

  // Bus ownership as seen from the pad side.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    TIMEOUT = 2'd2
  } bus_state_t;

  // Defaults sized for a 50 MHz system clock.
  localparam int DEF_FILT_CYCLES    = 5;        // 100 ns
  localparam int DEF_HOLD_CYCLES    = 15;       // 300 ns
  localparam int DEF_TIMEOUT_CYCLES = 1250000;  // 25 ms

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a stability filter for one raw pad line.
// The filtered level only follows the synchronised input after it has
// differed from the current level for FILT_CYCLES consecutive cycles.
// A one-cycle fall strobe is raised in the cycle the level is about to
// drop, so downstream logic can react on the same edge the level changes.
module i2c_glitch_filter
  import i2c_cond_pkg::*;
#(
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;

  // The level flips on the cycle the disagreement run reaches its final count.
  assign accept_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);
  assign fall     = accept_s && level_r;
  assign level    = level_r;

  // Synchronise the pad and count how long it has disagreed with the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (accept_s) begin
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_line_conditioner.sv
// Pad-side stage in front of the I2C slave bridge: filters SCL/SDA towards
// the bridge, registers the bridge's pull-down requests onto the pads with
// an SDA hold window after SCL falls, tracks START/STOP and bus ownership,
// and lets go of a bus whose SCL stays low too long while a transfer is open.
module i2c_line_conditioner
  import i2c_cond_pkg::*;
#(
  parameter int FILT_CYCLES    = DEF_FILT_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic scl_pad_in,
  input  logic sda_pad_in,
  output logic scl_pad_oe,
  output logic sda_pad_oe,
  output logic bridge_clk_in,
  output logic bridge_data_in,
  input  logic bridge_clk_oe,
  input  logic bridge_data_oe,
  input  logic timeout_clr,
  output logic start_pulse,
  output logic stop_pulse,
  output logic bus_busy,
  output logic bus_timeout
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [TW-1:0] LOW_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic          scl_f_s;
  logic          sda_f_s;
  logic          scl_fall_s;
  logic          sda_fall_unused_s;  // SDA falls are handled via the delayed copy
  logic          scl_d_r;
  logic          sda_d_r;
  logic          start_s;
  logic          stop_s;
  logic          enter_to_s;
  bus_state_t    state_r;
  bus_state_t    state_nxt_s;
  logic [TW-1:0] low_cnt_r;
  logic [HW-1:0] hold_cnt_r;
  logic          start_pulse_r;
  logic          stop_pulse_r;
  logic          bus_busy_r;
  logic          bus_timeout_r;
  logic          scl_oe_r;
  logic          sda_oe_r;

  i2c_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_scl_filt (
    .clk   (clk_clk),
    .reset (reset_reset),
    .raw   (scl_pad_in),
    .level (scl_f_s),
    .fall  (scl_fall_s)
  );

  i2c_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_sda_filt (
    .clk   (clk_clk),
    .reset (reset_reset),
    .raw   (sda_pad_in),
    .level (sda_f_s),
    .fall  (sda_fall_unused_s)
  );

  // SDA moving while SCL is steadily high; a simultaneous SCL change is no event.
  assign start_s    = scl_d_r && scl_f_s && sda_d_r && !sda_f_s;
  assign stop_s     = scl_d_r && scl_f_s && !sda_d_r && sda_f_s;
  assign enter_to_s = (state_r == BUSY) && (state_nxt_s == TIMEOUT);

  assign bridge_clk_in  = scl_f_s;
  assign bridge_data_in = sda_f_s;
  assign scl_pad_oe     = scl_oe_r;
  assign sda_pad_oe     = sda_oe_r;
  assign start_pulse    = start_pulse_r;
  assign stop_pulse     = stop_pulse_r;
  assign bus_busy       = bus_busy_r;
  assign bus_timeout    = bus_timeout_r;

  // Next bus state from START/STOP events and the SCL-low watchdog.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = BUSY;
        else         state_nxt_s = IDLE;
      end
      BUSY: begin
        if (stop_s)                     state_nxt_s = IDLE;
        else if (start_s)               state_nxt_s = BUSY;
        else if (low_cnt_r == LOW_LAST) state_nxt_s = TIMEOUT;
        else                            state_nxt_s = BUSY;
      end
      TIMEOUT: begin
        if (scl_f_s && sda_f_s) state_nxt_s = IDLE;
        else                    state_nxt_s = TIMEOUT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, delayed line copies, event pulses and status flags.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_r       <= IDLE;
      scl_d_r       <= 1'b1;
      sda_d_r       <= 1'b1;
      start_pulse_r <= 1'b0;
      stop_pulse_r  <= 1'b0;
      bus_busy_r    <= 1'b0;
      bus_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      scl_d_r       <= scl_f_s;
      sda_d_r       <= sda_f_s;
      start_pulse_r <= start_s;
      stop_pulse_r  <= stop_s;
      bus_busy_r    <= (state_nxt_s == BUSY);
      if (enter_to_s)       bus_timeout_r <= 1'b1;
      else if (timeout_clr) bus_timeout_r <= 1'b0;
      else                  bus_timeout_r <= bus_timeout_r;
    end
  end

  // Count consecutive SCL-low cycles while a transfer stays open.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      low_cnt_r <= {TW{1'b0}};
    end else if ((state_r == BUSY) && (state_nxt_s == BUSY) && !scl_f_s) begin
      if (low_cnt_r == LOW_LAST) low_cnt_r <= low_cnt_r;
      else                       low_cnt_r <= low_cnt_r + TW'(1);
    end else begin
      low_cnt_r <= {TW{1'b0}};
    end
  end

  // SDA hold window, (re)armed on the edge the filtered SCL drops.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hold_cnt_r <= {HW{1'b0}};
    end else if (scl_fall_s) begin
      hold_cnt_r <= HOLD_LOAD;
    end else if (hold_cnt_r != {HW{1'b0}}) begin
      hold_cnt_r <= hold_cnt_r - HW'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Pad pull-downs: follow the bridge, freeze SDA in the hold window, release on timeout.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      scl_oe_r <= 1'b0;
      sda_oe_r <= 1'b0;
    end else if (state_nxt_s == TIMEOUT) begin
      scl_oe_r <= 1'b0;
      sda_oe_r <= 1'b0;
    end else begin
      scl_oe_r <= bridge_clk_oe;
      if (hold_cnt_r != {HW{1'b0}}) sda_oe_r <= sda_oe_r;
      else                          sda_oe_r <= bridge_data_oe;
    end
  end

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Bench for i2c_line_conditioner: directed scenarios plus random pad traffic,
// every cycle compared against a behavioural model of the line conditioner.
module tb_i2c_line_conditioner;

  localparam int FILT = 5;
  localparam int HOLD = 15;
  localparam int TOUT = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_pad = 1'b1, sda_pad = 1'b1;
  logic bclk_oe = 1'b0, bdata_oe = 1'b0, tclr = 1'b0;
  logic scl_pad_oe, sda_pad_oe, bridge_clk_in, bridge_data_in;
  logic start_pulse, stop_pulse, bus_busy, bus_timeout;

  int total = 0;
  int bad = 0;

  // Model state
  bit q_scl[$];
  bit q_sda[$];
  bit m_scl_f, m_sda_f, m_scl_p, m_sda_p;
  bit m_start, m_stop, m_busy, m_stuck, m_tout, m_scl_oe, m_sda_oe;
  int m_low, m_hold;

  i2c_line_conditioner #(
    .FILT_CYCLES(FILT), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .scl_pad_in     (scl_pad),
    .sda_pad_in     (sda_pad),
    .scl_pad_oe     (scl_pad_oe),
    .sda_pad_oe     (sda_pad_oe),
    .bridge_clk_in  (bridge_clk_in),
    .bridge_data_in (bridge_data_in),
    .bridge_clk_oe  (bclk_oe),
    .bridge_data_oe (bdata_oe),
    .timeout_clr    (tclr),
    .start_pulse    (start_pulse),
    .stop_pulse     (stop_pulse),
    .bus_busy       (bus_busy),
    .bus_timeout    (bus_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // A level is accepted once the synced samples two to FILT+1 edges back
  // (i.e. the last FILT synced cycles) all disagree with it.
  function automatic bit filt_next(input bit q[$], input bit cur);
    int idx;
    bit s;
    for (int k = 2; k < 2 + FILT; k++) begin
      idx = q.size() - 1 - k;
      s = (idx >= 0) ? q[idx] : 1'b1;
      if (s == cur) return cur;
    end
    return !cur;
  endfunction

  task automatic model_step();
    bit nscl, nsda, st, sp, nbusy, nstuck;
    if (rst) begin
      q_scl.delete(); q_sda.delete();
      m_scl_f = 1; m_sda_f = 1; m_scl_p = 1; m_sda_p = 1;
      m_start = 0; m_stop = 0; m_busy = 0; m_stuck = 0; m_tout = 0;
      m_scl_oe = 0; m_sda_oe = 0; m_low = 0; m_hold = 0;
    end else begin
      q_scl.push_back(scl_pad); q_sda.push_back(sda_pad);
      if (q_scl.size() > 10) void'(q_scl.pop_front());
      if (q_sda.size() > 10) void'(q_sda.pop_front());
      nscl = filt_next(q_scl, m_scl_f);
      nsda = filt_next(q_sda, m_sda_f);
      st = m_scl_p && m_scl_f && m_sda_p && !m_sda_f;
      sp = m_scl_p && m_scl_f && !m_sda_p && m_sda_f;
      nbusy = m_busy; nstuck = m_stuck;
      if (m_stuck) begin
        if (m_scl_f && m_sda_f) nstuck = 0;
      end else if (m_busy) begin
        if (sp) nbusy = 0;
        else if (!st && m_low == TOUT - 1) begin nbusy = 0; nstuck = 1; end
      end else if (st) begin
        nbusy = 1;
      end
      if (m_busy && nstuck) m_tout = 1;
      else if (tclr) m_tout = 0;
      if (nstuck) begin
        m_scl_oe = 0; m_sda_oe = 0;
      end else begin
        m_scl_oe = bclk_oe;
        if (m_hold == 0) m_sda_oe = bdata_oe;
      end
      if (m_scl_f && !nscl) m_hold = HOLD;
      else if (m_hold > 0) m_hold--;
      m_low = (m_busy && nbusy && !m_scl_f) ? m_low + 1 : 0;
      m_start = st; m_stop = sp;
      m_busy = nbusy; m_stuck = nstuck;
      m_scl_p = m_scl_f; m_sda_p = m_sda_f;
      m_scl_f = nscl; m_sda_f = nsda;
    end
  endtask

  // One clock: advance model on the edge, compare every output mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("bridge_clk_in", bridge_clk_in, m_scl_f);
    check_eq("bridge_data_in", bridge_data_in, m_sda_f);
    check_eq("start_pulse", start_pulse, m_start);
    check_eq("stop_pulse", stop_pulse, m_stop);
    check_eq("bus_busy", bus_busy, m_busy);
    check_eq("bus_timeout", bus_timeout, m_tout);
    check_eq("scl_pad_oe", scl_pad_oe, m_scl_oe);
    check_eq("sda_pad_oe", sda_pad_oe, m_sda_oe);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick until bridge_clk_in reads low, bounded.
  task automatic wait_scl_low();
    int n;
    n = 0;
    while (bridge_clk_in !== 1'b0 && n < 30) begin tick(); n++; end
    check_eq("scl_filtered_fell", bridge_clk_in, 1'b0);
  endtask

  initial begin
    int n;
    bit seen, lo;
    int scl_left, sda_left;

    // Reset
    tick_n(3);
    rst = 1'b0;
    tick_n(2);
    check_eq("rst_clk_in", bridge_clk_in, 1'b1);
    check_eq("rst_data_in", bridge_data_in, 1'b1);
    check_eq("rst_pads", {scl_pad_oe, sda_pad_oe}, 2'b00);
    check_eq("rst_status", {start_pulse, stop_pulse, bus_busy, bus_timeout}, 4'b0000);

    // Glitch of 4 cycles is rejected
    sda_pad = 1'b0; tick_n(4); sda_pad = 1'b1;
    lo = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); lo = lo & bridge_data_in; end
    check_eq("glitch_rejected", lo, 1'b1);

    // Latency of a real edge, then START one cycle later
    sda_pad = 1'b0;
    n = 0;
    while (bridge_data_in !== 1'b0 && n < 20) begin tick(); n++; end
    check_eq("sda_latency", n, 7);
    tick();
    check_eq("start_seen", start_pulse, 1'b1);
    check_eq("busy_after_start", bus_busy, 1'b1);
    tick();
    check_eq("start_one_cycle", start_pulse, 1'b0);

    // Repeated START keeps the bus busy
    scl_pad = 1'b0; tick_n(10);
    sda_pad = 1'b1; tick_n(10);
    scl_pad = 1'b1; tick_n(10);
    sda_pad = 1'b0;
    seen = 1'b0; lo = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); seen |= start_pulse; lo &= bus_busy; end
    check_eq("rep_start_pulse", seen, 1'b1);
    check_eq("rep_start_busy", lo, 1'b1);

    // SDA hold after filtered SCL fall
    scl_pad = 1'b0;
    wait_scl_low();
    tick_n(2);
    bdata_oe = 1'b1;
    n = 2;
    while (sda_pad_oe !== 1'b1 && n < 40) begin tick(); n++; end
    check_eq("hold_release", n, 16);

    // STOP
    scl_pad = 1'b1; tick_n(10);
    bdata_oe = 1'b0;
    sda_pad = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); seen |= stop_pulse; end
    check_eq("stop_seen", seen, 1'b1);
    check_eq("idle_after_stop", bus_busy, 1'b0);

    // Timeout with the bridge pulling both lines
    sda_pad = 1'b0; tick_n(12);
    bclk_oe = 1'b1; bdata_oe = 1'b1;
    scl_pad = 1'b0;
    wait_scl_low();
    n = 0;
    while (bus_timeout !== 1'b1 && n < 200) begin tick(); n++; end
    check_eq("timeout_cycles", n, TOUT);
    check_eq("timeout_pads", {scl_pad_oe, sda_pad_oe}, 2'b00);
    tick_n(5);
    check_eq("timeout_pads_held", {scl_pad_oe, sda_pad_oe}, 2'b00);
    scl_pad = 1'b1; sda_pad = 1'b1; tick_n(15);
    check_eq("released_scl_follows", scl_pad_oe, 1'b1);
    tclr = 1'b1; tick(); tclr = 1'b0;
    check_eq("timeout_cleared", bus_timeout, 1'b0);
    bclk_oe = 1'b0; bdata_oe = 1'b0;

    // Clear coincident with timeout entry: set wins
    sda_pad = 1'b0; tick_n(12);
    scl_pad = 1'b0;
    wait_scl_low();
    tick_n(TOUT - 1);
    tclr = 1'b1; tick(); tclr = 1'b0;
    check_eq("set_beats_clear", bus_timeout, 1'b1);
    scl_pad = 1'b1; sda_pad = 1'b1; tick_n(15);
    tclr = 1'b1; tick(); tclr = 1'b0; tick();

    // Reset mid-transfer
    sda_pad = 1'b0; tick_n(12);
    bclk_oe = 1'b1; tick_n(2);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("midrst_pad", scl_pad_oe, 1'b0);
    check_eq("midrst_busy_stop", {bus_busy, stop_pulse}, 2'b00);
    bclk_oe = 1'b0; sda_pad = 1'b1; tick_n(12);

    // Random traffic
    scl_left = 1; sda_left = 1;
    for (int c = 0; c < 4000; c++) begin
      if (--scl_left == 0) begin scl_pad = $urandom_range(0, 1); scl_left = $urandom_range(1, 12); end
      if (--sda_left == 0) begin sda_pad = $urandom_range(0, 1); sda_left = $urandom_range(1, 12); end
      if ($urandom_range(0, 3) == 0) bclk_oe = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) bdata_oe = $urandom_range(0, 1);
      tclr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; tclr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
